// File: rtl/branch_resolve_unit.sv
// Branch resolution for the 2-wide pipe: resolves both slots against a static
// not-taken prediction, redirects fetch on a mispredict and drains the front end.
module branch_resolve_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        br_en,
  input  logic [2:0]        cond0,
  input  logic [2:0]        cond1,
  input  logic [1:0]        lt,
  input  logic [1:0]        eq,
  input  logic [ADDR_W-1:0] tgt0,
  input  logic [ADDR_W-1:0] tgt1,
  output logic              resolve_valid,
  output logic [1:0]        slot_taken,
  output logic              slot_kill,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  mispred_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_e;

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic                resolve_q;
  logic [1:0]          taken_q;
  logic                kill_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept, t0, t1, mispred;
  logic [1:0]          taken_d;
  logic [ADDR_W-1:0]   pc_d;

  function automatic logic cond_taken(input logic [2:0] c, input logic l, input logic e);
    case (c)
      3'b000:  return e;
      3'b001:  return ~e;
      3'b010:  return l;
      3'b011:  return ~l;
      3'b100:  return l | e;
      3'b101:  return ~l & ~e;
      3'b110:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    accept  = in_valid & (state_q == S_IDLE);
    t0      = br_en[0] & cond_taken(cond0, lt[0], eq[0]);
    t1      = br_en[1] & cond_taken(cond1, lt[1], eq[1]);
    mispred = t0 | t1;
    // Older slot wins: a taken slot 0 squashes slot 1's result.
    taken_d = t0 ? 2'b01 : {t1, 1'b0};
    pc_d    = t0 ? tgt0 : (t1 ? tgt1 : '0);
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: if (accept && mispred) state_d = S_REDIRECT;
      S_REDIRECT: begin
        if (redirect_ready) begin
          fcnt_d  = FLUSH_LD;
          state_d = (FLUSH_LD == 4'd0) ? S_IDLE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      resolve_q <= 1'b0;
      taken_q   <= '0;
      kill_q    <= 1'b0;
      pc_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      resolve_q <= accept;
      if (accept) begin
        taken_q <= taken_d;
        kill_q  <= t0;
        pc_q    <= pc_d;
        if (mispred && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready       = (state_q == S_IDLE);
    resolve_valid  = resolve_q;
    slot_taken     = resolve_q ? taken_q : 2'b00;
    slot_kill      = resolve_q & kill_q;
    redirect_valid = (state_q == S_REDIRECT);
    redirect_pc    = (state_q == S_REDIRECT) ? pc_q : '0;
    flush          = (state_q != S_IDLE);
    mispred_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit; dut_a uses default
// parameters, dut_b uses FLUSH_CYCLES=0 and a 2-bit counter for saturation.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        redirect_ready = 1'b0;
  logic [1:0]  br_en = '0, lt = '0, eq = '0;
  logic [2:0]  cond0 = '0, cond1 = '0;
  logic [31:0] tgt0 = '0, tgt1 = '0;
  logic        sel = 1'b0;

  logic        a_ir, a_rv, a_sk, a_redv, a_fl;
  logic [1:0]  a_st;
  logic [31:0] a_pc;
  logic [15:0] a_cnt;
  logic        b_ir, b_rv, b_sk, b_redv, b_fl;
  logic [1:0]  b_st;
  logic [31:0] b_pc;
  logic [1:0]  b_cnt;

  int unsigned vectors = 0;
  int unsigned fails = 0;
  int unsigned exp_cnt [2] = '{0, 0};
  int unsigned cnt_max [2] = '{65535, 3};
  int unsigned fcyc    [2] = '{2, 0};

  always #5 clk = ~clk;

  branch_resolve_unit #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(a_ir),
    .br_en(br_en), .cond0(cond0), .cond1(cond1), .lt(lt), .eq(eq),
    .tgt0(tgt0), .tgt1(tgt1), .resolve_valid(a_rv), .slot_taken(a_st),
    .slot_kill(a_sk), .redirect_valid(a_redv), .redirect_ready(redirect_ready & ~sel),
    .redirect_pc(a_pc), .flush(a_fl), .mispred_cnt(a_cnt));

  branch_resolve_unit #(.ADDR_W(32), .FLUSH_CYCLES(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(b_ir),
    .br_en(br_en), .cond0(cond0), .cond1(cond1), .lt(lt), .eq(eq),
    .tgt0(tgt0), .tgt1(tgt1), .resolve_valid(b_rv), .slot_taken(b_st),
    .slot_kill(b_sk), .redirect_valid(b_redv), .redirect_ready(redirect_ready & sel),
    .redirect_pc(b_pc), .flush(b_fl), .mispred_cnt(b_cnt));

  // Observed status of the selected DUT: {resolve_valid, slot_taken, slot_kill, redirect_valid, flush, in_ready}
  logic [6:0]  o_stat;
  logic [31:0] o_pc;
  logic [15:0] o_cnt;
  assign o_stat = sel ? {b_rv, b_st, b_sk, b_redv, b_fl, b_ir} : {a_rv, a_st, a_sk, a_redv, a_fl, a_ir};
  assign o_pc   = sel ? b_pc : a_pc;
  assign o_cnt  = sel ? 16'(b_cnt) : a_cnt;

  function automatic bit model_taken(input logic [2:0] c, input bit l, input bit e);
    case (c)
      3'd0: return e;
      3'd1: return !e;
      3'd2: return l;
      3'd3: return !l;
      3'd4: return l || e;
      3'd5: return !l && !e;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Applies one bundle at a negedge and follows it until the unit is idle again.
  task automatic do_bundle(input logic [1:0] b, input logic [2:0] c0, input logic [2:0] c1,
                           input logic [1:0] l, input logic [1:0] e,
                           input logic [31:0] p0, input logic [31:0] p1, input int unsigned hold);
    bit x0, x1, mis;
    logic [31:0] xpc;
    logic [6:0]  xs;
    x0  = b[0] && model_taken(c0, l[0], e[0]);
    x1  = b[1] && model_taken(c1, l[1], e[1]);
    mis = x0 || x1;
    xpc = x0 ? p0 : (x1 ? p1 : 32'd0);
    br_en = b; cond0 = c0; cond1 = c1; lt = l; eq = e; tgt0 = p0; tgt1 = p1;
    in_valid = 1'b1;
    vectors++;
    if (o_stat[0] !== 1'b1) begin fails++; $display("FAIL accept_ready got %b exp 1", o_stat[0]); end
    @(negedge clk);
    in_valid = 1'b0;
    if (mis && exp_cnt[sel] < cnt_max[sel]) exp_cnt[sel]++;
    xs = {1'b1, x1 && !x0, x0, x0, mis, mis, !mis};
    vectors++;
    if (o_stat !== xs) begin fails++; $display("FAIL resolve_stat got %b exp %b", o_stat, xs); end
    vectors++;
    if (o_pc !== xpc) begin fails++; $display("FAIL resolve_pc got %h exp %h", o_pc, xpc); end
    vectors++;
    if (o_cnt !== 16'(exp_cnt[sel])) begin fails++; $display("FAIL mispred_cnt got %0d exp %0d", o_cnt, exp_cnt[sel]); end
    if (!mis) return;
    for (int unsigned i = 0; i < hold; i++) begin
      // Unrelated traffic while busy must not be accepted.
      in_valid = 1'b1; cond0 = 3'd6; br_en = 2'b01; tgt0 = $urandom;
      @(negedge clk);
      vectors++;
      if (o_stat !== 7'b0000110 || o_pc !== xpc) begin
        fails++; $display("FAIL hold_redirect got %b/%h exp 0000110/%h", o_stat, o_pc, xpc);
      end
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    for (int unsigned i = 0; i < fcyc[sel]; i++) begin
      vectors++;
      if (o_stat !== 7'b0000010 || o_pc !== 32'd0) begin
        fails++; $display("FAIL flush_drain cyc %0d got %b/%h exp 0000010/0", i, o_stat, o_pc);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (o_stat !== 7'b0000001) begin fails++; $display("FAIL back_idle got %b exp 0000001", o_stat); end
  endtask

  task automatic test_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      vectors++;
      if (o_stat !== 7'b0000001 || o_pc !== 32'd0 || o_cnt !== 16'd0) begin
        fails++; $display("FAIL reset_state sel %0d got %b/%h/%0d exp 0000001/0/0", s, o_stat, o_pc, o_cnt);
      end
    end
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_slot0_taken();
    sel = 1'b0;
    do_bundle(2'b01, 3'b010, 3'b000, 2'b01, 2'b00, 32'h1000_0040, 32'h2000_0080, 3);
  endtask

  task automatic test_both_beq();
    sel = 1'b0;
    do_bundle(2'b11, 3'b000, 3'b000, 2'b00, 2'b11, 32'hAAAA_0000, 32'hBBBB_0000, 1);
  endtask

  task automatic test_slot1_bgt();
    sel = 1'b0;
    do_bundle(2'b10, 3'b000, 3'b101, 2'b00, 2'b00, 32'h0000_1111, 32'hCAFE_F00C, 0);
  endtask

  task automatic test_never_taken();
    sel = 1'b0;
    do_bundle(2'b11, 3'b111, 3'b111, 2'b11, 2'b11, 32'h1, 32'h2, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0;
    sel = 1'b0;
    c0 = o_cnt;
    for (int i = 0; i < 6; i++) begin
      br_en = 2'b11; cond0 = 3'b011; cond1 = 3'b011; lt = 2'b11; eq = 2'($urandom);
      tgt0 = $urandom; tgt1 = $urandom; in_valid = 1'b1;
      vectors++;
      if (o_stat[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready idx %0d got 0 exp 1", i); end
      if (i > 0) begin
        vectors++;
        if (o_stat !== 7'b1000001) begin fails++; $display("FAIL b2b_resolve idx %0d got %b exp 1000001", i, o_stat); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (o_stat !== 7'b1000001 || o_cnt !== c0) begin
      fails++; $display("FAIL b2b_last got %b/%0d exp 1000001/%0d", o_stat, o_cnt, c0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    sel = 1'b0;
    br_en = 2'b01; cond0 = 3'b110; tgt0 = 32'h55; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk); redirect_ready = 1'b0;
    vectors++;
    if (o_stat !== 7'b0000010) begin fails++; $display("FAIL in_flush got %b exp 0000010", o_stat); end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = '{0, 0};
    vectors++;
    if (o_stat !== 7'b0000001 || o_pc !== 32'd0 || o_cnt !== 16'd0) begin
      fails++; $display("FAIL async_reset got %b/%h/%0d exp 0000001/0/0", o_stat, o_pc, o_cnt);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    do_bundle(2'b10, 3'b000, 3'b110, 2'b00, 2'b00, 32'h9, 32'h7777_0000, 1);
  endtask

  task automatic test_saturate();
    sel = 1'b1;
    for (int i = 0; i < 5; i++)
      do_bundle(2'b01, 3'b100, 3'b000, 2'b00, 2'b01, $urandom, $urandom, 32'(i % 2));
    do_bundle(2'b01, 3'b111, 3'b000, 2'b11, 2'b11, 32'h3, 32'h4, 0);
    sel = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom_range(0, 3) == 0);
      do_bundle(2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
                $urandom, $urandom, $urandom_range(0, 3));
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slot0_taken();
    test_both_beq();
    test_slot1_bgt();
    test_never_taken();
    test_back_to_back();
    test_reset_mid_flush();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
